// File: rtl/envase_pkg.sv
// Shared definitions for the bottling line controller.
//   estado_t  : state encoding, also exported on the estado debug port
//   DUZIA     : approved bottles per dozen
//   ROLHA_W   : cork stock width (0..99)
//   GARRAFA_W : bottle-in-dozen width (0..11)
package envase_pkg;

    typedef enum logic [2:0] {
        PARADO     = 3'd0,
        AVANCA     = 3'd1,
        ENCHE      = 3'd2,
        VEDA       = 3'd3,
        INSPECIONA = 3'd4,
        DESCARTA   = 3'd5,
        SAIDA      = 3'd6,
        FALHA      = 3'd7
    } estado_t;

    localparam int DUZIA     = 12;
    localparam int ROLHA_W   = 7;
    localparam int GARRAFA_W = 4;

endpackage

// File: rtl/controlador_envase_if.sv
// Sensor / actuator bundle of the bottling line controller.
//   slave  : controller side (sensors in, actuators and counts out)
//   master : line / display side
//   sensors   : start, pg, ch, cq, eb, repor
//   actuators : motor, valvula, vedar, descarte
//   status    : inc_duzia, garrafas, rolhas, alarme, estado
interface controlador_envase_if;
    import envase_pkg::*;

    logic                 start;
    logic                 pg;
    logic                 ch;
    logic                 cq;
    logic                 eb;
    logic                 repor;
    logic                 motor;
    logic                 valvula;
    logic                 vedar;
    logic                 descarte;
    logic                 inc_duzia;
    logic [GARRAFA_W-1:0] garrafas;
    logic [ROLHA_W-1:0]   rolhas;
    logic                 alarme;
    logic [2:0]           estado;

    modport slave (
        input  start, pg, ch, cq, eb, repor,
        output motor, valvula, vedar, descarte, inc_duzia,
               garrafas, rolhas, alarme, estado
    );

    modport master (
        output start, pg, ch, cq, eb, repor,
        input  motor, valvula, vedar, descarte, inc_duzia,
               garrafas, rolhas, alarme, estado
    );

endinterface

// File: rtl/temporizador_estado.sv
// 8-bit state timer shared by the fill (ENCHE) and capping (VEDA) states.
//   clock, reset : system clock, async active-high reset
//   clr          : synchronous clear (takes priority over en)
//   en           : count enable
//   lim          : terminal value
//   fim          : high while the count equals lim
module temporizador_estado (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] lim,
    output logic       fim
);

    logic [7:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign fim = (cnt == lim);

endmodule

// File: rtl/controlador_envase.sv
// Bottling line sequencing FSM: conveyor, fill valve, capper and reject gate,
// plus the bottle-per-dozen and cork stock counts for the display datapath.
//   clock, reset : system clock, async active-high reset
//   linha        : sensor inputs and registered (Moore) outputs
// Optional build macro ROLHA_AUTO_REPOR_EN: cork stock reloads automatically
// when it runs out at a bottle boundary instead of stopping the line.
module controlador_envase
    import envase_pkg::*;
#(
    parameter int ROLHAS_INI  = 99,
    parameter int T_ENCHE_MAX = 200,
    parameter int T_VEDA      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    controlador_envase_if.slave  linha
);

    localparam logic [ROLHA_W-1:0] ROLHAS_CARGA = ROLHA_W'(ROLHAS_INI);

    estado_t              estado, prox;
    logic [ROLHA_W-1:0]   rolhas, rolhas_prox;
    logic [GARRAFA_W-1:0] garrafas;
    logic                 motor, valvula, vedar, descarte, inc_duzia, alarme;
    logic                 fim;
    logic [7:0]           lim;

    // Timer restarts on every state change, so each visit to ENCHE/VEDA counts from 0.
    assign lim = (estado == ENCHE) ? 8'(T_ENCHE_MAX - 1) : 8'(T_VEDA - 1);

    temporizador_estado u_temp (
        .clock (clock),
        .reset (reset),
        .clr   (prox != estado),
        .en    ((estado == ENCHE) || (estado == VEDA)),
        .lim   (lim),
        .fim   (fim)
    );

    always_comb begin
        prox        = estado;
        rolhas_prox = rolhas;
        case (estado)
            PARADO: begin
                if (linha.repor)
                    rolhas_prox = ROLHAS_CARGA;
                if (linha.start && rolhas != '0)
                    prox = AVANCA;
            end
            AVANCA: begin
                if (linha.pg)
                    prox = ENCHE;
                else if (!linha.start)
                    prox = PARADO;
            end
            ENCHE: begin
                // bottle full wins over a simultaneous timeout
                if (linha.ch)
                    prox = VEDA;
                else if (fim)
                    prox = FALHA;
            end
            VEDA: begin
                if (fim) begin
                    prox = INSPECIONA;
                    if (rolhas != '0)
                        rolhas_prox = rolhas - 1'b1;
                end
            end
            INSPECIONA: prox = linha.cq ? SAIDA : DESCARTA;
            SAIDA, DESCARTA: begin
                if (linha.eb) begin
`ifdef ROLHA_AUTO_REPOR_EN
                    if (rolhas == '0)
                        rolhas_prox = ROLHAS_CARGA;
                    prox = linha.start ? AVANCA : PARADO;
`else
                    prox = (linha.start && rolhas != '0) ? AVANCA : PARADO;
`endif
                end
            end
            FALHA: begin
                if (linha.repor)
                    rolhas_prox = ROLHAS_CARGA;
                if (!linha.start)
                    prox = PARADO;
            end
            default: prox = PARADO;
        endcase
    end

    // Outputs are decoded from the next state so they line up with estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= PARADO;
            rolhas    <= ROLHAS_CARGA;
            garrafas  <= '0;
            motor     <= 1'b0;
            valvula   <= 1'b0;
            vedar     <= 1'b0;
            descarte  <= 1'b0;
            inc_duzia <= 1'b0;
            alarme    <= 1'b0;
        end else begin
            estado    <= prox;
            rolhas    <= rolhas_prox;
            motor     <= (prox == AVANCA) || (prox == SAIDA) || (prox == DESCARTA);
            valvula   <= (prox == ENCHE);
            vedar     <= (prox == VEDA);
            descarte  <= (prox == DESCARTA);
            alarme    <= (prox == FALHA) || ((prox == PARADO) && (rolhas_prox == '0));
            inc_duzia <= 1'b0;
            if (estado == SAIDA && linha.eb) begin
                if (garrafas == GARRAFA_W'(DUZIA - 1)) begin
                    garrafas  <= '0;
                    inc_duzia <= 1'b1;
                end else begin
                    garrafas <= garrafas + 1'b1;
                end
            end
        end
    end

    assign linha.motor     = motor;
    assign linha.valvula   = valvula;
    assign linha.vedar     = vedar;
    assign linha.descarte  = descarte;
    assign linha.inc_duzia = inc_duzia;
    assign linha.garrafas  = garrafas;
    assign linha.rolhas    = rolhas;
    assign linha.alarme    = alarme;
    assign linha.estado    = estado;

endmodule

// File: tb/tb_controlador_envase.sv
// Bench for controlador_envase: main unit with default stock, second unit with
// a single cork. Bottle-boundary counts go through a scoreboard queue.
module tb_controlador_envase;

    logic clock = 1'b0;
    logic rst1  = 1'b1;
    logic rst2  = 1'b1;
    logic sel   = 1'b0;
    logic start = 1'b0, pg = 1'b0, ch = 1'b0, cq = 1'b0, eb = 1'b0, repor = 1'b0;

    always #5 clock = ~clock;

    controlador_envase_if b1 ();
    controlador_envase_if b2 ();

    assign b1.start = start; assign b1.pg = pg; assign b1.ch = ch;
    assign b1.cq = cq; assign b1.eb = eb; assign b1.repor = repor;
    assign b2.start = start; assign b2.pg = pg; assign b2.ch = ch;
    assign b2.cq = cq; assign b2.eb = eb; assign b2.repor = repor;

    controlador_envase dut1 (.clock(clock), .reset(rst1), .linha(b1));
    controlador_envase #(.ROLHAS_INI(1)) dut2 (.clock(clock), .reset(rst2), .linha(b2));

    logic [2:0] o_est;
    logic [3:0] o_gar;
    logic [6:0] o_rol;
    logic       o_motor, o_val, o_ved, o_desc, o_inc, o_alm, o_rst;

    assign o_est   = sel ? b2.estado    : b1.estado;
    assign o_gar   = sel ? b2.garrafas  : b1.garrafas;
    assign o_rol   = sel ? b2.rolhas    : b1.rolhas;
    assign o_motor = sel ? b2.motor     : b1.motor;
    assign o_val   = sel ? b2.valvula   : b1.valvula;
    assign o_ved   = sel ? b2.vedar     : b1.vedar;
    assign o_desc  = sel ? b2.descarte  : b1.descarte;
    assign o_inc   = sel ? b2.inc_duzia : b1.inc_duzia;
    assign o_alm   = sel ? b2.alarme    : b1.alarme;
    assign o_rst   = sel ? rst2 : rst1;

    typedef struct { int gar; int rol; } exp_t;
    exp_t q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int n_duz  = 0;
    int m_gar, m_rol, m_ini;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_est(string tag, int alvo, int lim);
        int n = 0;
        while (o_est != 3'(alvo) && n < lim) begin
            tick;
            n++;
        end
        chk(tag, o_est, alvo);
    endtask

    task automatic run_bottle(int aprov);
        int n = 0;
        wait_est("avanca", 1, 10);
        chk("motor_avanca", o_motor, 1);
        pg = 1'b1;
        wait_est("enche", 2, 5);
        chk("valvula", o_val, 1);
        pg = 1'b0;
        ch = 1'b1;
        wait_est("veda", 3, 5);
        ch = 1'b0;
        cq = aprov[0];
        while (o_est == 3'd3 && n < 20) begin
            n++;
            tick;
        end
        chk("t_veda", n, 4);
        chk("inspeciona", o_est, 4);
        tick;
        cq = 1'b0;
        wait_est(aprov != 0 ? "saida" : "descarta", aprov != 0 ? 6 : 5, 3);
        chk("descarte", o_desc, aprov != 0 ? 0 : 1);
        chk("motor_saida", o_motor, 1);
        m_rol = m_rol - 1;
        if (aprov != 0) m_gar = (m_gar + 1) % 12;
`ifdef ROLHA_AUTO_REPOR_EN
        if (m_rol == 0) m_rol = m_ini;
`endif
        q.push_back('{gar: m_gar, rol: m_rol});
        eb = 1'b1;
        tick;
        eb = 1'b0;
    endtask

    logic [2:0] prev_est = 3'd0;
    logic       prev_inc = 1'b0;

    always @(negedge clock) begin
        if (o_rst) begin
            prev_est <= 3'd0;
            prev_inc <= 1'b0;
        end else begin
            if ((prev_est == 3'd5 || prev_est == 3'd6) && o_est != prev_est) begin
                if (q.size() == 0) begin
                    chk("sb_vazio", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_garrafas", o_gar, e.gar);
                    chk("sb_rolhas", o_rol, e.rol);
                end
            end
            if (o_inc) begin
                n_duz++;
                chk("duzia_1ciclo", prev_inc, 0);
            end
            prev_est <= o_est;
            prev_inc <= o_inc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_gar = 0; m_rol = 99; m_ini = 99;
        tick; tick;
        chk("rst_estado", o_est, 0);
        chk("rst_motor", o_motor, 0);
        chk("rst_rolhas", o_rol, 99);
        chk("rst_garrafas", o_gar, 0);
        chk("rst_alarme", o_alm, 0);
        chk("rst_inc", o_inc, 0);
        rst1 = 1'b0;
        tick;
        chk("parado_sem_start", o_est, 0);
        start = 1'b1;

        run_bottle(1);
        chk("b1_garrafas", o_gar, 1);
        chk("b1_rolhas", o_rol, 98);
        chk("b1_inc", o_inc, 0);

        for (int i = 0; i < 11; i++) run_bottle(1);
        chk("duzia_inc", o_inc, 1);
        chk("duzia_garrafas", o_gar, 0);
        chk("duzia_rolhas", o_rol, 87);
        tick;
        chk("duzia_inc_baixo", o_inc, 0);
        tick;
        chk("duzia_pulsos", n_duz, 1);

        run_bottle(0);
        tick;
        chk("rej_garrafas", o_gar, 0);
        chk("rej_rolhas", o_rol, 86);

        // fill timeout, with a repor pulse that must be ignored in ENCHE
        begin
            int n = 0;
            wait_est("avanca_f", 1, 10);
            pg = 1'b1;
            wait_est("enche_f", 2, 5);
            pg = 1'b0;
            while (o_est == 3'd2 && n < 300) begin
                repor = (n == 5);
                n++;
                tick;
            end
            repor = 1'b0;
            chk("t_enche", n, 200);
        end
        chk("falha", o_est, 7);
        chk("falha_alarme", o_alm, 1);
        chk("falha_motor", o_motor, 0);
        chk("repor_ignorado", o_rol, 86);
        start = 1'b0;
        tick;
        chk("falha_parado", o_est, 0);
        chk("parado_alarme", o_alm, 0);

        // reset in the middle of VEDA
        start = 1'b1;
        wait_est("avanca_r", 1, 10);
        pg = 1'b1;
        wait_est("enche_r", 2, 5);
        pg = 1'b0;
        ch = 1'b1;
        wait_est("veda_r", 3, 5);
        ch = 1'b0;
        tick;
        #2;
        rst1 = 1'b1;
        #1;
        chk("rst_veda_estado", o_est, 0);
        chk("rst_veda_vedar", o_ved, 0);
        chk("rst_veda_motor", o_motor, 0);
        chk("rst_veda_rolhas", o_rol, 99);
        chk("rst_veda_garrafas", o_gar, 0);
        q.delete();
        start = 1'b0;
        tick;

        // single-cork unit
        sel = 1'b1;
        m_gar = 0; m_rol = 1; m_ini = 1;
        rst2 = 1'b0;
        tick;
        chk("u2_rolhas", o_rol, 1);
        start = 1'b1;
        run_bottle(1);
`ifdef ROLHA_AUTO_REPOR_EN
        chk("u2_estado", o_est, 1);
        chk("u2_alarme", o_alm, 0);
        chk("u2_rolhas_recarga", o_rol, 1);
`else
        chk("u2_estado", o_est, 0);
        chk("u2_alarme", o_alm, 1);
        chk("u2_rolhas_zero", o_rol, 0);
        tick;
        chk("u2_fica_parado", o_est, 0);
        repor = 1'b1;
        tick;
        repor = 1'b0;
        chk("u2_repor", o_rol, 1);
        chk("u2_repor_alarme", o_alm, 0);
        tick;
        chk("u2_rearranque", o_est, 1);
`endif
        tick; tick;
        chk("sb_final", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_envase.md
Name: controlador_envase

Overview:
- Sequencing FSM for the bottling line: drives conveyor, fill valve, capper and reject gate from the station sensors.
- Owns the bottle-per-dozen count and the cork stock count that feed the existing 0–99 counters and 7-segment decoders.
- Sits between the raw sensor inputs (start, pg, ch, cq, eb) and the display datapath.
- Emits a one-cycle dozen pulse and a binary cork stock value.

Parameters:
- ROLHAS_INI, 99, cork stock loaded at reset and on refill; range 1..99.
- T_ENCHE_MAX, 200, fill timeout in cycles; range 2..255.
- T_VEDA, 4, capper-active duration in cycles; range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  run-enable level; already synchronous to clock.
- pg  in  1  bottle present at fill station.
- ch  in  1  bottle full.
- cq  in  1  quality OK (1 = approve), sampled in INSPECIONA.
- eb  in  1  bottle passed exit sensor.
- repor  in  1  manual cork refill request.
- motor  out  1  conveyor on.
- valvula  out  1  fill valve open.
- vedar  out  1  capper active.
- descarte  out  1  reject gate open.
- inc_duzia  out  1  one-cycle pulse per 12 approved bottles.
- garrafas  out  4  approved bottles in current dozen, 0..11.
- rolhas  out  7  cork stock, 0..99.
- alarme  out  1  fault / out-of-corks indicator.
- estado  out  3  current state encoding, for debug and display.

Behaviour:
- Reset values: state PARADO; all actuator outputs, inc_duzia, garrafas and timer = 0; rolhas = ROLHAS_INI.
- All outputs are registered (Moore). Actuators are high during their state only.
- Bottle boundary = the cycle that exits SAIDA or DESCARTA.
- States and transitions:
  - PARADO (0): no actuators on. Go to AVANCA if start=1 and rolhas>0.
  - AVANCA (1): motor=1. Go to ENCHE when pg=1. If start=0 and pg=0, go to PARADO.
  - ENCHE (2): valvula=1; timer counts from 0.
    - If ch=1, go to VEDA.
    - If timer reaches T_ENCHE_MAX-1 with ch=0, go to FALHA.
    - If ch=1 on the timeout cycle, ch wins.
  - VEDA (3): vedar=1 for exactly T_VEDA cycles. On exit, rolhas decrements by 1, then go to INSPECIONA.
  - INSPECIONA (4): one cycle; sample cq. cq=1 goes to SAIDA; cq=0 goes to DESCARTA.
  - SAIDA (6): motor=1 until eb=1. On that cycle, garrafas increments.
    - At garrafas=11 it wraps to 0 and inc_duzia pulses on the following cycle.
  - DESCARTA (5): motor=1 and descarte=1 until eb=1. No count change; the cork stays consumed.
  - At a bottle boundary: if rolhas=0 or start=0, go to PARADO; else go to AVANCA.
  - FALHA (7): all actuators 0, alarme=1. Go to PARADO when start=0 (operator acknowledge).
- alarme = 1 in FALHA, or in PARADO with rolhas=0.
- repor: loads rolhas = ROLHAS_INI. Honoured only in PARADO or FALHA; ignored elsewhere. It therefore never collides with the VEDA decrement.
- rolhas never decrements below 0. VEDA is unreachable with rolhas=0.
- garrafas counts approved bottles only. No saturation; mod-12 wrap only.
- Sensor levels held across several cycles cause no double-counting: each count or decrement is tied to a state exit.
- Reset mid-operation: immediate return to reset values; a partially filled bottle is not counted.

Optional Feature:
- Macro: ROLHA_AUTO_REPOR_EN.
- With the macro defined: when rolhas=0 at a bottle boundary, rolhas reloads to ROLHAS_INI in that same cycle. The line continues to AVANCA if start=1, and alarme stays 0.
- Without the macro: the line stops in PARADO with alarme=1 until repor.

Decomposition:
- Package envase_pkg holds:
  - state encodings: PARADO=0, AVANCA=1, ENCHE=2, VEDA=3, INSPECIONA=4, DESCARTA=5, SAIDA=6, FALHA=7;
  - DUZIA=12, ROLHA_W=7, GARRAFA_W=4.
- One sub-module: temporizador_estado. It is an 8-bit up-counter with clear and enable and a terminal-compare output, shared by ENCHE and VEDA.

Test Plan:
- Reset, then start=1 with pg, ch, cq=1 and eb each asserted once → state sequence 1,2,3,4,6; rolhas=98, garrafas=1, inc_duzia=0.
- Twelve approved bottles → garrafas wraps 11→0; exactly one inc_duzia pulse, one cycle long; rolhas=87.
- cq=0 on a bottle → descarte=1 until eb; garrafas unchanged; rolhas still decremented.
- ch held 0 in ENCHE → FALHA after T_ENCHE_MAX cycles with alarme=1; start=0 → PARADO.
- Set rolhas=1 via ROLHAS_INI=1, then run one bottle:
  - without macro → PARADO with alarme=1; repor restores rolhas to 1;
  - with macro → rolhas reloads and the line stays in AVANCA.
- reset asserted mid-VEDA → all outputs 0 and rolhas=ROLHAS_INI in the same cycle; repor pulsed during ENCHE is ignored.
